// File: rtl/squeeze_rd_arbiter.sv
// Alternating-burst read arbiter: drains the 3x3 and 1x1 squeeze FIFOs into one
// tagged valid/ready stream, holding up to two words against downstream backpressure.
module squeeze_rd_arbiter #(
  parameter int DATA_W = 96,
  parameter int LEN_W  = 8,
  parameter int PAIR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  burst_3x3_len_i,
  input  logic [LEN_W-1:0]  burst_1x1_len_i,
  input  logic [PAIR_W-1:0] num_pairs_i,
  input  logic [DATA_W-1:0] fifo_sq_3x3_rd_data_i,
  output logic              fifo_sq_3x3_rd_en_o,
  input  logic              fifo_sq_3x3_empty_i,
  input  logic [DATA_W-1:0] fifo_sq_1x1_rd_data_i,
  output logic              fifo_sq_1x1_rd_en_o,
  input  logic              fifo_sq_1x1_empty_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_src_o,
  output logic              out_last_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {IDLE, RD_3X3, RD_1X1, DRAIN, FIN} state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  len3_q, len1_q, wcnt_q;
  logic [PAIR_W-1:0] pairs_q, pcnt_q;
  logic              busy_q, done_q;

  logic              infl_q, infl_src_q, infl_last_q;
  logic [DATA_W-1:0] buf_data_q [2];
  logic [1:0]        buf_src_q, buf_last_q;
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        occ_q, occ_d;

  logic              accept, room, rd3, rd1, pop, burst_end;
  logic              head_vld, bypass, cap, deq;
  logic [LEN_W-1:0]  cur_len;
  logic [DATA_W-1:0] infl_data;

  assign accept    = out_valid_o & out_ready_i;
  assign room      = (({1'b0, occ_q} + {2'b0, infl_q}) - {2'b0, accept}) < 3'd2;
  assign rd3       = (state_q == RD_3X3) & ~fifo_sq_3x3_empty_i & room;
  assign rd1       = (state_q == RD_1X1) & ~fifo_sq_1x1_empty_i & room;
  assign pop       = rd3 | rd1;
  assign cur_len   = (state_q == RD_1X1) ? len1_q : len3_q;
  assign burst_end = (wcnt_q == cur_len);

  assign fifo_sq_3x3_rd_en_o = rd3;
  assign fifo_sq_1x1_rd_en_o = rd1;

  // With the buffer empty, the word arriving from the FIFO is presented directly;
  // if it is not taken it lands in the buffer and stays on the port unchanged.
  assign infl_data = infl_src_q ? fifo_sq_1x1_rd_data_i : fifo_sq_3x3_rd_data_i;
  assign head_vld  = (occ_q != 2'd0);
  assign bypass    = ~head_vld & infl_q & accept;
  assign cap       = infl_q & ~bypass;
  assign deq       = head_vld & accept;
  assign occ_d     = occ_q + {1'b0, cap} - {1'b0, deq};

  assign out_valid_o = head_vld | infl_q;
  assign out_data_o  = head_vld ? buf_data_q[rd_ptr_q] : (infl_q ? infl_data : '0);
  assign out_src_o   = head_vld ? buf_src_q[rd_ptr_q]  : (infl_q & infl_src_q);
  assign out_last_o  = head_vld ? buf_last_q[rd_ptr_q] : (infl_q & infl_last_q);
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      len3_q  <= '0;
      len1_q  <= '0;
      pairs_q <= '0;
      wcnt_q  <= '0;
      pcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          len3_q  <= burst_3x3_len_i;
          len1_q  <= burst_1x1_len_i;
          pairs_q <= num_pairs_i;
          wcnt_q  <= '0;
          pcnt_q  <= '0;
          busy_q  <= 1'b1;
          state_q <= RD_3X3;
        end
        RD_3X3, RD_1X1: if (pop) begin
          if (burst_end) begin
            wcnt_q <= '0;
            if (state_q == RD_3X3) state_q <= RD_1X1;
            else if (pcnt_q == pairs_q) state_q <= DRAIN;
            else begin
              pcnt_q  <= pcnt_q + 1'b1;
              state_q <= RD_3X3;
            end
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        // Done fires in the cycle after the final word leaves; FIN keeps start
        // from being honoured during the done pulse.
        DRAIN: if (occ_d == 2'd0) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= FIN;
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      infl_q        <= 1'b0;
      infl_src_q    <= 1'b0;
      infl_last_q   <= 1'b0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_src_q     <= '0;
      buf_last_q    <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      occ_q         <= '0;
    end else begin
      infl_q <= pop;
      if (pop) begin
        infl_src_q  <= rd1;
        infl_last_q <= burst_end;
      end
      if (cap) begin
        buf_data_q[wr_ptr_q] <= infl_data;
        buf_src_q[wr_ptr_q]  <= infl_src_q;
        buf_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

endmodule
